pe_array_feeder: RTL

PE_ARRAY_FEEDER -- requirements
Module: pe_array_feeder

---
 rtl/pe_array_pkg.sv | 17 +
 rtl/skew_delay_line.sv | 36 +++
 rtl/pe_array_feeder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pe_array_pkg.sv
// pe_array_pkg
// Shared definitions for the PE-array feeder slice: default operand width,
// default systolic array dimension and the feeder state encoding.
// No ports (package).
package pe_array_pkg;

  localparam int PE_DATA_WIDTH    = 8;
  localparam int PE_SYSTOLIC_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line
// One lane of operand skew: a DEPTH-stage register pipeline, all stages
// cleared by synchronous active-low reset.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   din   - lane data in
//   dout  - lane data delayed by DEPTH cycles
module skew_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pe_array_feeder.sv
// pe_array_feeder
// Reads k_len operand vectors from the IFM and weight buffers and feeds them
// into an S x S systolic array with the diagonal skew the array needs (lane i
// delayed by i+1 registers), plus a one-hot accumulator-start pulse that walks
// along the 2S-1 diagonals.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start, k_len        - tile request and reduction length (sampled in IDLE)
//   rd_en, rd_addr      - shared buffer read strobe/address
//   ifm_rd_data         - IFM vector, valid one cycle after rd_en
//   wgt_rd_data         - weight vector, valid one cycle after rd_en
//   left_in, top_in     - skewed row/column operands (zero when idle)
//   set_reg_compute     - per-diagonal accumulator-start pulse
//   busy, done          - tile in progress / one-cycle completion pulse
//   busy_cycles         - only with PE_ARRAY_FEEDER_PERF_EN: saturating count
//                         of busy cycles since reset
module pe_array_feeder
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH    = PE_DATA_WIDTH,
  parameter int SYSTOLIC_SIZE = PE_SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH    = 10
) (
`ifdef PE_ARRAY_FEEDER_PERF_EN
  output logic [31:0]                          busy_cycles,
`endif
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                k_len,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]  ifm_rd_data,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]  wgt_rd_data,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]  left_in,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]  top_in,
  output logic [2*SYSTOLIC_SIZE-2:0]           set_reg_compute,
  output logic                                 busy,
  output logic                                 done
);

  localparam int S     = SYSTOLIC_SIZE;
  localparam int NDIAG = 2*S - 1;
  // DRAIN lasts 2S-1 cycles so DONE lands when the last element reaches
  // diagonal 2S-2.
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(NDIAG - 1);

  feeder_state_t         state, next_state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] k_len_q;
  logic                  rd_en_q;
  logic                  first_q;
  logic [NDIAG-1:0]      diag_sr;

  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (k_len == '0) ? DONE : READ;
      end
      READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (cnt == k_len_q - ADDR_WIDTH'(1)) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt == DRAIN_LAST) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign rd_addr = rd_en ? cnt : '0;

  // One counter serves both READ (address) and DRAIN (cycles left); it restarts
  // on every state change so each phase counts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      k_len_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) k_len_q <= k_len;
      if (state == IDLE || next_state != state) cnt <= '0;
      else                                      cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

  // rd_en_q marks cycles where buffer data is real; first_q marks element 0,
  // which launches the diagonal pulse one cycle before lane 0 outputs it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      first_q <= 1'b0;
      diag_sr <= '0;
    end else begin
      rd_en_q <= rd_en;
      first_q <= rd_en && (cnt == '0);
      diag_sr <= {diag_sr[NDIAG-2:0], first_q};
    end
  end

  assign set_reg_compute = diag_sr;

  // Buffer data is forced to zero outside valid cycles so stale or undefined
  // buffer contents never enter the skew lines.
  for (genvar i = 0; i < S; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] ifm_lane;
    logic [DATA_WIDTH-1:0] wgt_lane;

    assign ifm_lane = rd_en_q ? ifm_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign wgt_lane = rd_en_q ? wgt_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_ifm_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (ifm_lane),
      .dout (left_in[i*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_wgt_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (wgt_lane),
      .dout (top_in[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef PE_ARRAY_FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                           busy_cycles <= '0;
    else if (busy && busy_cycles != '1)   busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule
